multi_key_debounce: RTL and testbench

MULTI_KEY_DEBOUNCE -- requirements
Module: multi_key_debounce

---
 rtl/key_pkg.sv | 38 +++
 rtl/key_channel.sv | 147 ++++++++++++++
 rtl/multi_key_debounce.sv | 75 +++++++
 tb/tb_multi_key_debounce.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debouncer.
// Channel FSM encoding and ms-to-tick sizing helpers.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_LONG_HELD,
        ST_RELEASE_DB
    } key_state_t;

    // sys_clk cycles per 1 ms tick; never below one cycle
    function automatic int unsigned ms_to_tick_div(
        input int unsigned clk_hz
    );
        return (clk_hz >= 1000) ? (clk_hz / 1000) : 1;
    endfunction

    function automatic int unsigned bits_for_max(
        input int unsigned max_val
    );
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: debounce FSM with press/release/long/repeat events.
// All timing counts shared 1 ms ticks; counters saturate.
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200,
    parameter int unsigned CNT_W       = 10
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic tick,
    input  logic key_sync,
    output logic key_value,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam logic [CNT_W-1:0] DB_T    = CNT_W'(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] LONG_T  = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] REP_T   = CNT_W'(REPEAT_MS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic LONG_EN = (LONG_MS != 0);
    localparam logic REP_EN  = (LONG_MS != 0) && (REPEAT_MS != 0);

    key_state_t state, state_nxt;

    logic [CNT_W-1:0] db_cnt, db_cnt_nxt, db_inc;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt, hold_inc;
    logic from_long, from_long_nxt;
    logic value_nxt;
    logic press_nxt, release_nxt, long_nxt, repeat_nxt;

    assign db_inc   = (db_cnt == CNT_MAX)
                    ? db_cnt : db_cnt + CNT_W'(1);
    assign hold_inc = (hold_cnt == CNT_MAX)
                    ? hold_cnt : hold_cnt + CNT_W'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            from_long   <= 1'b0;
            key_value   <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state       <= state_nxt;
            db_cnt      <= db_cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            from_long   <= from_long_nxt;
            key_value   <= value_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_long    <= long_nxt;
            key_repeat  <= repeat_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        db_cnt_nxt    = db_cnt;
        hold_cnt_nxt  = hold_cnt;
        from_long_nxt = from_long;
        value_nxt     = key_value;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;
        repeat_nxt    = 1'b0;

        // hold/repeat time keeps running through a release bounce
        if (tick) begin
            hold_cnt_nxt = hold_inc;
        end

        unique case (state)
            ST_IDLE: begin
                if (!key_sync) begin
                    state_nxt  = ST_PRESS_DB;
                    db_cnt_nxt = '0;
                end
            end
            ST_PRESS_DB: begin
                if (key_sync) begin
                    state_nxt  = ST_IDLE;
                    db_cnt_nxt = '0;
                end else if (tick) begin
                    if (db_inc >= DB_T) begin
                        state_nxt     = ST_HELD;
                        press_nxt     = 1'b1;
                        value_nxt     = 1'b0;
                        hold_cnt_nxt  = '0;
                        from_long_nxt = 1'b0;
                    end else begin
                        db_cnt_nxt = db_inc;
                    end
                end
            end
            ST_HELD: begin
                if (key_sync) begin
                    state_nxt     = ST_RELEASE_DB;
                    db_cnt_nxt    = '0;
                    from_long_nxt = 1'b0;
                end else if (LONG_EN && tick
                             && hold_inc >= LONG_T) begin
                    state_nxt    = ST_LONG_HELD;
                    long_nxt     = 1'b1;
                    hold_cnt_nxt = '0;
                end
            end
            ST_LONG_HELD: begin
                if (key_sync) begin
                    state_nxt     = ST_RELEASE_DB;
                    db_cnt_nxt    = '0;
                    from_long_nxt = 1'b1;
                end else if (REP_EN && tick
                             && hold_inc >= REP_T) begin
                    repeat_nxt   = 1'b1;
                    hold_cnt_nxt = '0;
                end
            end
            ST_RELEASE_DB: begin
                if (!key_sync) begin
                    state_nxt = from_long ? ST_LONG_HELD : ST_HELD;
                end else if (tick) begin
                    if (db_inc >= DB_T) begin
                        state_nxt   = ST_IDLE;
                        release_nxt = 1'b1;
                        value_nxt   = 1'b1;
                    end else begin
                        db_cnt_nxt = db_inc;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/multi_key_debounce.sv
// Multi-key debouncer: shared 1 ms tick, 2-FF synchronizers,
// one key_channel per key.
module multi_key_debounce
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_value,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    localparam int unsigned TICK_DIV = ms_to_tick_div(CLK_FREQ_HZ);
    localparam int unsigned DIV_W    = bits_for_max(TICK_DIV - 1);
    localparam int unsigned CNT_W    =
        bits_for_max(max3(DEBOUNCE_MS, LONG_MS, REPEAT_MS));
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [NUM_KEYS-1:0] sync_q1;
    logic [NUM_KEYS-1:0] sync_q2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // synchronizers reset to the released level so reset never looks like a press
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .REPEAT_MS   (REPEAT_MS),
            .CNT_W       (CNT_W)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .tick        (tick),
            .key_sync    (sync_q2[i]),
            .key_value   (key_value[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Scoreboard bench for multi_key_debounce (10 cycles per ms tick).
// Stimulus queues expected events; a negedge monitor pops and compares.
module tb_multi_key_debounce;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    typedef struct {
        int         kind;
        logic [3:0] mask;
        int         lo;
        int         hi;
    } exp_t;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] key_in;
    logic [3:0] key_value;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;
    logic [3:0] key_repeat;

    exp_t sb[$];
    exp_t e;
    int   ecount = 0;
    int   checks = 0;
    int   passes = 0;
    int   c0;

    multi_key_debounce #(
        .NUM_KEYS    (4),
        .CLK_FREQ_HZ (10_000),
        .DEBOUNCE_MS (20),
        .LONG_MS     (100),
        .REPEAT_MS   (30)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_value   (key_value),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // posedges since reset release; ecount % 10 tracks the tick phase
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ecount <= 0;
        else            ecount <= ecount + 1;
    end

    function automatic string kname(input int k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            K_LONG:    return "long";
            default:   return "repeat";
        endcase
    endfunction

    always @(negedge sys_clk) begin
        logic [3:0] v [4];
        v[0] = key_press;
        v[1] = key_release;
        v[2] = key_long;
        v[3] = key_repeat;
        for (int k = 0; k < 4; k++) begin
            if (v[k] != 4'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_%s: got mask %b at t=%0d, required no event",
                             kname(k), v[k], ecount);
                end else begin
                    e = sb.pop_front();
                    if (e.kind == k && e.mask == v[k]
                        && ecount >= e.lo && ecount <= e.hi) begin
                        passes++;
                    end else begin
                        $display("FAIL event_%s: got %s mask %b at t=%0d, required %s mask %b in [%0d,%0d]",
                                 kname(e.kind), kname(k), v[k], ecount,
                                 kname(e.kind), e.mask, e.lo, e.hi);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] req);
        checks++;
        if (got === req) passes++;
        else $display("FAIL %s: got %h, required %h", name, got, req);
    endtask

    task automatic expect_ev(input int kind, input logic [3:0] mask,
                             input int lo, input int hi);
        exp_t x;
        x.kind = kind;
        x.mask = mask;
        x.lo   = lo;
        x.hi   = hi;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (ecount < t) step();
    endtask

    // edge lands just after tick phase 7: press/release latency is 202 cycles
    task automatic align();
        do step(); while (ecount % 10 != 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        sys_rst_n = 1'b0;
        key_in    = 4'hF;
        repeat (3) @(negedge sys_clk);
        check("rst_value", {12'h0, key_value}, 16'h000F);
        check("rst_pulses",
              {key_press, key_release, key_long, key_repeat}, 16'h0);
        sys_rst_n = 1'b1;

        // clean press held 500 cycles
        align();
        c0 = ecount;
        expect_ev(K_PRESS, 4'b0001, c0 + 200, c0 + 212);
        key_in[0] = 1'b0;
        wait_until(c0 + 300);
        check("press_value", {12'h0, key_value}, 16'h000E);
        wait_until(c0 + 500);
        key_in[0] = 1'b1;
        expect_ev(K_RELEASE, 4'b0001, c0 + 700, c0 + 712);
        wait_until(c0 + 800);
        check("release_value", {12'h0, key_value}, 16'h000F);

        // bounce then stable press
        for (int i = 0; i < 5; i++) begin
            key_in[0] = 1'b0;
            repeat (30) step();
            key_in[0] = 1'b1;
            repeat (30) step();
        end
        align();
        c0 = ecount;
        key_in[0] = 1'b0;
        expect_ev(K_PRESS, 4'b0001, c0 + 200, c0 + 212);
        wait_until(c0 + 400);
        check("bounce_value", {12'h0, key_value}, 16'h000E);
        key_in[0] = 1'b1;
        expect_ev(K_RELEASE, 4'b0001, c0 + 600, c0 + 612);
        wait_until(c0 + 700);

        // 150-cycle press is too short
        align();
        key_in[0] = 1'b0;
        repeat (150) step();
        key_in[0] = 1'b1;
        repeat (300) step();
        check("short_value", {12'h0, key_value}, 16'h000F);

        // long hold with a 50-cycle release bounce
        align();
        c0 = ecount;
        key_in[0] = 1'b0;
        expect_ev(K_PRESS,   4'b0001, c0 + 200,  c0 + 212);
        expect_ev(K_LONG,    4'b0001, c0 + 1198, c0 + 1206);
        expect_ev(K_REPEAT,  4'b0001, c0 + 1498, c0 + 1506);
        expect_ev(K_REPEAT,  4'b0001, c0 + 1798, c0 + 1806);
        expect_ev(K_RELEASE, 4'b0001, c0 + 2200, c0 + 2212);
        wait_until(c0 + 1600);
        key_in[0] = 1'b1;
        wait_until(c0 + 1650);
        key_in[0] = 1'b0;
        wait_until(c0 + 1900);
        check("hold_value", {12'h0, key_value}, 16'h000E);
        wait_until(c0 + 2000);
        key_in[0] = 1'b1;
        wait_until(c0 + 2300);
        check("hold_rel_value", {12'h0, key_value}, 16'h000F);

        // keys 0 and 3 together
        align();
        c0 = ecount;
        key_in = 4'b0110;
        expect_ev(K_PRESS, 4'b1001, c0 + 200, c0 + 212);
        wait_until(c0 + 400);
        check("dual_value", {12'h0, key_value}, 16'h0006);
        key_in = 4'hF;
        expect_ev(K_RELEASE, 4'b1001, c0 + 600, c0 + 612);
        wait_until(c0 + 700);
        check("dual_rel_value", {12'h0, key_value}, 16'h000F);

        // reset while long-held, key stays down
        align();
        c0 = ecount;
        key_in[0] = 1'b0;
        expect_ev(K_PRESS, 4'b0001, c0 + 200,  c0 + 212);
        expect_ev(K_LONG,  4'b0001, c0 + 1198, c0 + 1206);
        wait_until(c0 + 1300);
        check("long_value", {12'h0, key_value}, 16'h000E);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_value", {12'h0, key_value}, 16'h000F);
        check("midrst_pulses",
              {key_press, key_release, key_long, key_repeat}, 16'h0);
        repeat (5) @(negedge sys_clk);
        expect_ev(K_PRESS, 4'b0001, 200, 204);
        sys_rst_n = 1'b1;
        wait_until(400);
        check("repress_value", {12'h0, key_value}, 16'h000E);
        align();
        c0 = ecount;
        key_in[0] = 1'b1;
        expect_ev(K_RELEASE, 4'b0001, c0 + 200, c0 + 212);
        wait_until(c0 + 300);

        repeat (20) step();
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL sb_drain: got %0d pending events, required 0",
                      sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
